// File: rtl/aes_serial_loader_if.sv
// Beat-in / block-out bundle for the AES serial loader.
// master drives beats and accepts blocks; slave is the loader.
interface aes_serial_loader_if #(
  parameter int BEAT_BYTES = 1
);
  logic [8*BEAT_BYTES-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              nk;
  logic                    key_reuse;
  logic                    abort;
  logic [127:0]            pt_out;
  logic [255:0]            key_out;
  logic [3:0]              nk_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;
  logic [15:0]             blk_cnt;

  modport master (
    output in_data,
    output in_valid,
    output nk,
    output key_reuse,
    output abort,
    output out_ready,
    input  in_ready,
    input  pt_out,
    input  key_out,
    input  nk_out,
    input  out_valid,
    input  err,
    input  blk_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  nk,
    input  key_reuse,
    input  abort,
    input  out_ready,
    output in_ready,
    output pt_out,
    output key_out,
    output nk_out,
    output out_valid,
    output err,
    output blk_cnt
  );
endinterface

// File: rtl/aes_serial_loader.sv
// Serial byte-beat loader assembling AES plaintext and key
// blocks for the EncryptNK4/6/8 cores.
module aes_serial_loader #(
  parameter int BEAT_BYTES = 1
) (
  input logic              clk,
  input logic              rst_n,
  aes_serial_loader_if.slave bus
);
  localparam int BW = 8 * BEAT_BYTES;
  localparam logic [5:0] STEP = 6'(BEAT_BYTES);

  typedef enum logic [1:0] {
    LOAD_PT,
    LOAD_KEY,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [5:0]   cnt;
  logic [127:0] pt_q;
  logic [255:0] key_q;
  logic [3:0]   nk_q;
  logic         reuse_q;
  logic         key_vld;
  logic         err_q;
  logic [15:0]  blk_q;

  logic loading;
  logic ready;
  logic accept;
  logic first;
  logic nk_ok;
  logic bad;
  logic pt_last;
  logic key_last;
  logic reuse_ok;

  always_comb begin
    loading  = (state == LOAD_PT) || (state == LOAD_KEY);
    ready    = rst_n && loading && !bus.abort;
    accept   = ready && bus.in_valid;
    first    = (state == LOAD_PT) && (cnt == 6'd0);
    nk_ok    = (bus.nk == 4'd4) || (bus.nk == 4'd6)
            || (bus.nk == 4'd8);
    bad      = accept && first && !nk_ok;
    pt_last  = accept && (state == LOAD_PT) && !bad
            && ((cnt + STEP) == 6'd16);
    key_last = accept && (state == LOAD_KEY)
            && ((cnt + STEP) == {nk_q, 2'b00});
    // a reuse request without a stored key reloads it
    reuse_ok = reuse_q && key_vld;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD_PT: begin
        if (bus.abort)
          state_nxt = LOAD_PT;
        else if (pt_last)
          state_nxt = reuse_ok ? HOLD : LOAD_KEY;
      end
      LOAD_KEY: begin
        if (bus.abort)
          state_nxt = LOAD_PT;
        else if (key_last)
          state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready)
          state_nxt = LOAD_PT;
      end
      default: state_nxt = LOAD_PT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= LOAD_PT;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      nk_q    <= '0;
      reuse_q <= 1'b0;
      key_vld <= 1'b0;
      err_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      err_q <= bad;
      unique case (state)
        LOAD_PT: begin
          if (bus.abort) begin
            cnt <= '0;
          end else if (accept && !bad) begin
            if (first) begin
              nk_q    <= bus.nk;
              reuse_q <= bus.key_reuse;
            end
            pt_q <= {pt_q[127-BW:0], bus.in_data};
            if (pt_last) begin
              cnt <= '0;
              if (!reuse_ok)
                key_q <= '0;
            end else begin
              cnt <= cnt + STEP;
            end
          end
        end
        LOAD_KEY: begin
          if (bus.abort) begin
            cnt     <= '0;
            key_vld <= 1'b0;
          end else if (accept) begin
            for (int b = 0; b < BEAT_BYTES; b++)
              key_q[8*(31-int'(cnt)-b) +: 8]
                <= bus.in_data[8*(BEAT_BYTES-1-b) +: 8];
            if (key_last) begin
              cnt     <= '0;
              key_vld <= 1'b1;
            end else begin
              cnt <= cnt + STEP;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready)
            blk_q <= blk_q + 16'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.pt_out    = pt_q;
  assign bus.key_out   = key_q;
  assign bus.nk_out    = nk_q;
  assign bus.err       = err_q;
  assign bus.blk_cnt   = blk_q;
endmodule

// File: tb/tb_aes_serial_loader.sv
// Directed bench for aes_serial_loader at 1- and 4-byte beats.
module tb_aes_serial_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_serial_loader_if #(.BEAT_BYTES(1)) ia ();
  aes_serial_loader_if #(.BEAT_BYTES(4)) ib ();

  aes_serial_loader #(.BEAT_BYTES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  aes_serial_loader #(.BEAT_BYTES(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] K4A =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K6 =
    {192'h404142434445464748494a4b4c4d4e4f5051525354555657,
     64'h0};
  localparam logic [255:0] K4F =
    {128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h0};
  localparam logic [255:0] K4T =
    {128'h101112131415161718191a1b1c1d1e1f, 128'h0};
  localparam logic [255:0] K8 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input logic [7:0] d);
    @(negedge clk);
    ia.in_data  = d;
    ia.in_valid = 1'b1;
    @(posedge clk);
    #1 ia.in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [31:0] d);
    @(negedge clk);
    ib.in_data  = d;
    ib.in_valid = 1'b1;
    @(posedge clk);
    #1 ib.in_valid = 1'b0;
  endtask

  task automatic hs_a();
    @(negedge clk);
    ia.out_ready = 1'b1;
    @(posedge clk);
    #1 ia.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic hs_b();
    @(negedge clk);
    ib.out_ready = 1'b1;
    @(posedge clk);
    #1 ib.out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ia.in_data = '0; ia.in_valid = 1'b0; ia.nk = 4'd4;
    ia.key_reuse = 1'b0; ia.abort = 1'b0; ia.out_ready = 1'b0;
    ib.in_data = '0; ib.in_valid = 1'b0; ib.nk = 4'd8;
    ib.key_reuse = 1'b0; ib.abort = 1'b0; ib.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", ia.in_ready, 0);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_err", ia.err, 0);
    chk("rst_blk_cnt", ia.blk_cnt, 0);
    chk("rst_pt", ia.pt_out, 0);
    chk("rst_key", ia.key_out, 0);
    chk("rst_nk", ia.nk_out, 0);
    chk("rst_b_in_ready", ib.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", ia.in_ready, 1);
    chk("rel_b_in_ready", ib.in_ready, 1);

    // Nk=4 block, byte beats
    for (int i = 0; i < 16; i++) beat_a(8'(i * 17));
    for (int i = 0; i < 15; i++) beat_a(8'(i));
    @(negedge clk);
    chk("nk4_ov_early", ia.out_valid, 0);
    beat_a(8'h0f);
    @(negedge clk);
    chk("nk4_ov", ia.out_valid, 1);
    chk("nk4_pt", ia.pt_out,
        128'h00112233445566778899aabbccddeeff);
    chk("nk4_key", ia.key_out, K4A);
    chk("nk4_nk", ia.nk_out, 4);
    chk("nk4_rdy", ia.in_ready, 0);
    hs_a();
    chk("nk4_blk", ia.blk_cnt, 1);
    chk("nk4_ov_done", ia.out_valid, 0);
    chk("nk4_rdy_done", ia.in_ready, 1);

    // Nk=6 block held for 5 cycles, abort ignored in HOLD
    ia.nk = 4'd6;
    for (int i = 0; i < 16; i++) beat_a(8'h20 + 8'(i));
    for (int i = 0; i < 24; i++) beat_a(8'h40 + 8'(i));
    ia.abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("nk6_hold_ov", ia.out_valid, 1);
      chk("nk6_hold_rdy", ia.in_ready, 0);
      chk("nk6_hold_pt", ia.pt_out,
          128'h202122232425262728292a2b2c2d2e2f);
      chk("nk6_hold_key", ia.key_out, K6);
    end
    ia.abort = 1'b0;
    chk("nk6_nk", ia.nk_out, 6);
    hs_a();
    chk("nk6_blk", ia.blk_cnt, 2);
    chk("nk6_rdy", ia.in_ready, 1);

    // key reuse: 16 beats only
    ia.key_reuse = 1'b1;
    for (int i = 0; i < 15; i++) beat_a(8'hf0 + 8'(i));
    @(negedge clk);
    chk("reuse_ov_early", ia.out_valid, 0);
    beat_a(8'hff);
    @(negedge clk);
    chk("reuse_ov", ia.out_valid, 1);
    chk("reuse_pt", ia.pt_out,
        128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    chk("reuse_key", ia.key_out, K6);
    hs_a();
    chk("reuse_blk", ia.blk_cnt, 3);

    // illegal Nk on first beat
    ia.key_reuse = 1'b0;
    ia.nk = 4'd5;
    beat_a(8'h99);
    ia.nk = 4'd4;
    @(negedge clk);
    chk("bad_err", ia.err, 1);
    chk("bad_ov", ia.out_valid, 0);
    @(negedge clk);
    chk("bad_err_once", ia.err, 0);
    chk("bad_rdy", ia.in_ready, 1);
    for (int i = 0; i < 16; i++) beat_a(8'(i));
    for (int i = 0; i < 16; i++) beat_a(8'hf0 + 8'(i));
    @(negedge clk);
    chk("after_bad_ov", ia.out_valid, 1);
    chk("after_bad_pt", ia.pt_out,
        128'h000102030405060708090a0b0c0d0e0f);
    chk("after_bad_key", ia.key_out, K4F);
    chk("after_bad_nk", ia.nk_out, 4);
    hs_a();
    chk("after_bad_blk", ia.blk_cnt, 4);

    // abort during plaintext load
    for (int i = 0; i < 10; i++) beat_a(8'hee);
    @(negedge clk);
    ia.abort = 1'b1;
    ia.in_valid = 1'b1;
    ia.in_data = 8'h77;
    #1;
    chk("abort_rdy", ia.in_ready, 0);
    @(posedge clk);
    #1 ia.abort = 1'b0;
    ia.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) beat_a(8'h80 + 8'(i));
    for (int i = 0; i < 16; i++) beat_a(8'(i));
    @(negedge clk);
    chk("abort_ov", ia.out_valid, 1);
    chk("abort_pt", ia.pt_out,
        128'h808182838485868788898a8b8c8d8e8f);
    chk("abort_key", ia.key_out, K4A);
    hs_a();
    chk("abort_blk", ia.blk_cnt, 5);

    // abort during key load drops the stored key
    for (int i = 0; i < 16; i++) beat_a(8'h55);
    for (int i = 0; i < 3; i++) beat_a(8'haa);
    @(negedge clk);
    ia.abort = 1'b1;
    @(posedge clk);
    #1 ia.abort = 1'b0;
    ia.key_reuse = 1'b1;
    for (int i = 0; i < 16; i++) beat_a(8'h33);
    @(negedge clk);
    chk("kabort_ov", ia.out_valid, 0);
    chk("kabort_rdy", ia.in_ready, 1);
    for (int i = 0; i < 16; i++) beat_a(8'h10 + 8'(i));
    @(negedge clk);
    chk("kabort_ov2", ia.out_valid, 1);
    chk("kabort_key", ia.key_out, K4T);
    hs_a();
    chk("kabort_blk", ia.blk_cnt, 6);

    // 4-byte beats, Nk=8
    beat_b(32'h00112233);
    beat_b(32'h44556677);
    beat_b(32'h8899aabb);
    beat_b(32'hccddeeff);
    for (int i = 0; i < 7; i++)
      beat_b({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    @(negedge clk);
    chk("b_ov_early", ib.out_valid, 0);
    beat_b(32'h1c1d1e1f);
    @(negedge clk);
    chk("b_ov", ib.out_valid, 1);
    chk("b_pt", ib.pt_out,
        128'h00112233445566778899aabbccddeeff);
    chk("b_key", ib.key_out, K8);
    chk("b_nk", ib.nk_out, 8);
    hs_b();
    chk("b_blk", ib.blk_cnt, 1);

    // reset in the middle of a key load
    for (int i = 0; i < 4; i++) beat_b(32'h5a5a5a5a);
    for (int i = 0; i < 6; i++) beat_b(32'ha5a5a5a5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("b_rst_ov", ib.out_valid, 0);
    chk("b_rst_rdy", ib.in_ready, 0);
    chk("b_rst_key", ib.key_out, 0);
    chk("b_rst_blk", ib.blk_cnt, 0);
    rst_n = 1'b1;
    ib.key_reuse = 1'b1;
    for (int i = 0; i < 4; i++) beat_b(32'h01020304);
    @(negedge clk);
    chk("b_nokey_ov", ib.out_valid, 0);
    chk("b_nokey_rdy", ib.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
